// File: rtl/data_memory_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl_pkg
// Description : Shared encodings for the data memory / memory-mapped IO unit:
//               access-mode codes, address-region codes, split-FSM states
//               and small decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package data_memory_ctrl_pkg;

    // Access width as driven by the core's decode stage
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Region select taken from address[13:12]
    localparam logic [1:0] REGION_RAM  = 2'b00;
    localparam logic [1:0] REGION_IN   = 2'b01;
    localparam logic [1:0] REGION_OUT  = 2'b10;
    localparam logic [1:0] REGION_NONE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    // Byte-lane mask of an access before it is shifted to its offset.
    // Unknown mode codes fall back to a full word.
    function automatic logic [3:0] mode_mask(input logic [1:0] mode);
        case (mode)
            MEM_BYTE: return 4'b0001;
            MEM_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // An access is misaligned when its byte lanes spill into the next word.
    function automatic logic is_misaligned(input logic [1:0] mode,
                                           input logic [1:0] offset);
        case (mode)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return (offset == 2'b11);
            default:  return (offset != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl_load_extend
// Description : Combinational load aligner. Takes a little-endian two-word
//               window, shifts it down by the byte offset, masks to the
//               access width and sign- or zero-extends the result.
// Ports       : window_i   [63:0] {upper word, lower word}
//               offset_i   [1:0]  byte offset within the lower word
//               mode_i     [1:0]  MEM_BYTE / MEM_HALF / MEM_WORD
//               unsigned_i        zero-extend when high
//               result_o   [31:0] extended load data
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module data_memory_ctrl_load_extend
    import data_memory_ctrl_pkg::*;
(
    input  logic [63:0] window_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  mode_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] aligned;

    always_comb begin
        aligned = 32'(window_i >> {offset_i, 3'b000});
        case (mode_i)
            MEM_BYTE: result_o = unsigned_i ? {24'h0, aligned[7:0]}
                                            : {{24{aligned[7]}}, aligned[7:0]};
            MEM_HALF: result_o = unsigned_i ? {16'h0, aligned[15:0]}
                                            : {{16{aligned[15]}}, aligned[15:0]};
            default:  result_o = aligned;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : RV32I data memory and memory-mapped IO. Byte/half/word loads
//               and stores; misaligned RAM accesses are split into two word
//               accesses with a one-cycle stall. Regions: RAM, synchronised
//               inputs with sticky rising-edge flags, output registers.
// Ports       : clock, reset        clock / synchronous active-high reset
//               req, wren           request, store(1)/load(0)
//               address [31:0]      byte address
//               mem_mode, mem_unsigned, data [31:0]  access mode and store data
//               stall               hold request stable while high
//               q [31:0], q_valid   registered load result and pulse
//               misalign_err        pulse on misaligned IO/unmapped access
//               io_input_bus        asynchronous inputs (IN_W bits)
//               io_output_bus       output registers, reg k at [32k+31:32k]
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int N_OUT_REGS = 4,
    parameter int IN_W       = 14
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    wren,
    input  logic [31:0]             address,
    input  logic [1:0]              mem_mode,
    input  logic                    mem_unsigned,
    input  logic [31:0]             data,
    output logic                    stall,
    output logic [31:0]             q,
    output logic                    q_valid,
    output logic                    misalign_err,
    input  logic [IN_W-1:0]         io_input_bus,
    output logic [32*N_OUT_REGS-1:0] io_output_bus
);

    localparam int AW = $clog2(RAM_WORDS);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]    region;
    logic [1:0]    offset;
    logic [AW-1:0] word_idx;
    logic [2:0]    reg_idx;
    logic          misalign;
    logic          idle_req;
    logic          split_start;
    logic [7:0]    be_full;
    logic [63:0]   wd_full;
    logic          unused_addr;

    state_e        state_q;
    logic          in_split;

    assign region    = address[13:12];
    assign offset    = address[1:0];
    assign word_idx  = address[AW+1:2];
    assign reg_idx   = address[4:2];
    assign misalign  = is_misaligned(mem_mode, offset);
    assign in_split  = (state_q == ST_SPLIT);
    assign idle_req  = !in_split && req;
    assign split_start = idle_req && misalign && (region == REGION_RAM);
    assign stall     = split_start && !reset;
    // Upper address bits are not decoded; the regions alias across them.
    assign unused_addr = ^address;

    // Lanes [3:0] belong to word n, lanes [7:4] spill into word n+1
    assign be_full = {4'b0000, mode_mask(mem_mode)} << offset;
    assign wd_full = {32'h0, data} << {offset, 3'b000};

    // ------------------------------------------------------------------
    // Split-access context, captured in the first cycle of a split
    // ------------------------------------------------------------------
    logic [AW-1:0] hi_idx_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_wd_q;
    logic [31:0]   lo_word_q;
    logic          wren_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [1:0]    mode_q;

    // ------------------------------------------------------------------
    // Byte-enabled RAM, single port shared between both split halves
    // ------------------------------------------------------------------
    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rd;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wd;

    assign ram_idx = in_split ? hi_idx_q : word_idx;
    assign ram_rd  = mem[ram_idx];
    // Reset suppresses any write, including the second half of a split
    assign ram_we  = !reset && (in_split ? wren_q
                                         : (idle_req && wren && (region == REGION_RAM)));
    assign ram_be  = in_split ? hi_be_q : be_full[3:0];
    assign ram_wd  = in_split ? hi_wd_q : wd_full[31:0];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) begin
                    mem[ram_idx][8*b +: 8] <= ram_wd[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input port: 2-flop synchroniser, a third flop for edge detection
    // ------------------------------------------------------------------
    logic [IN_W-1:0] sync1_q, sync2_q, sync3_q;
    logic [IN_W-1:0] flags_q, flags_d;
    logic [IN_W-1:0] rise;
    logic            flag_rd;
    logic [31:0]     in_word;
    logic [31:0]     flag_word;

    assign rise    = sync2_q & ~sync3_q;
    assign flag_rd = idle_req && !wren && !misalign
                     && (region == REGION_IN) && (reg_idx == 3'd1);
    // A clearing read drops the flags it returned; a new edge in the same
    // cycle survives because it is OR-ed in after the clear.
    assign flags_d = flag_rd ? rise : (flags_q | rise);

    always_comb begin
        in_word   = '0;
        flag_word = '0;
        in_word[IN_W-1:0]   = sync2_q;
        flag_word[IN_W-1:0] = flags_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            flags_q <= '0;
        end else begin
            sync1_q <= io_input_bus;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [31:0] out_q [N_OUT_REGS];
    logic [31:0] out_rd;
    logic        out_we;

    assign out_we = idle_req && wren && !misalign && (region == REGION_OUT);

    always_comb begin
        out_rd = '0;
        for (int k = 0; k < N_OUT_REGS; k++) begin
            if (reg_idx == 3'(k)) out_rd = out_q[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_OUT_REGS; k++) out_q[k] <= '0;
        end else if (out_we) begin
            for (int k = 0; k < N_OUT_REGS; k++) begin
                if (reg_idx == 3'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_full[b]) out_q[k][8*b +: 8] <= wd_full[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT_REGS; k++) begin : g_out_bus
        assign io_output_bus[32*k +: 32] = out_q[k];
    end

    // ------------------------------------------------------------------
    // Load path: one extender serves aligned and split loads
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [63:0] ext_window;
    logic [1:0]  ext_off;
    logic [1:0]  ext_mode;
    logic        ext_uns;
    logic [31:0] ext_result;

    always_comb begin
        rd_word = '0;
        case (region)
            REGION_RAM: rd_word = ram_rd;
            REGION_IN: begin
                if (reg_idx == 3'd0)      rd_word = in_word;
                else if (reg_idx == 3'd1) rd_word = flag_word;
            end
            REGION_OUT: rd_word = out_rd;
            default:    rd_word = '0;
        endcase
    end

    assign ext_window = in_split ? {ram_rd, lo_word_q} : {32'h0, rd_word};
    assign ext_off    = in_split ? off_q  : offset;
    assign ext_mode   = in_split ? mode_q : mem_mode;
    assign ext_uns    = in_split ? uns_q  : mem_unsigned;

    data_memory_ctrl_load_extend u_load_extend (
        .window_i   (ext_window),
        .offset_i   (ext_off),
        .mode_i     (ext_mode),
        .unsigned_i (ext_uns),
        .result_o   (ext_result)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    logic [31:0] q_q;
    logic        q_valid_q;
    logic        misalign_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            misalign_q <= 1'b0;
            hi_idx_q   <= '0;
            hi_be_q    <= '0;
            hi_wd_q    <= '0;
            lo_word_q  <= '0;
            wren_q     <= 1'b0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            mode_q     <= '0;
        end else begin
            q_valid_q  <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (split_start) begin
                        state_q   <= ST_SPLIT;
                        lo_word_q <= ram_rd;
                        hi_idx_q  <= word_idx + 1'b1;   // wraps at the top word
                        hi_be_q   <= be_full[7:4];
                        hi_wd_q   <= wd_full[63:32];
                        wren_q    <= wren;
                        uns_q     <= mem_unsigned;
                        off_q     <= offset;
                        mode_q    <= mem_mode;
                    end else if (idle_req && misalign) begin
                        misalign_q <= 1'b1;
                        if (!wren) begin
                            q_q       <= '0;
                            q_valid_q <= 1'b1;
                        end
                    end else if (idle_req && !wren) begin
                        q_q       <= ext_result;
                        q_valid_q <= 1'b1;
                    end
                end
                ST_SPLIT: begin
                    state_q <= ST_IDLE;
                    if (!wren_q) begin
                        q_q       <= ext_result;
                        q_valid_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign q            = q_q;
    assign q_valid      = q_valid_q;
    assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Self-checking bench for data_memory_ctrl. Load expectations
//               are queued when a load is issued and compared when q_valid
//               appears; register/flag side effects are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;
    import data_memory_ctrl_pkg::*;

    localparam int RAM_WORDS  = 1024;
    localparam int N_OUT_REGS = 4;
    localparam int IN_W       = 14;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     req;
    logic                     wren;
    logic [31:0]              address;
    logic [1:0]               mem_mode;
    logic                     mem_unsigned;
    logic [31:0]              data;
    logic                     stall;
    logic [31:0]              q;
    logic                     q_valid;
    logic                     misalign_err;
    logic [IN_W-1:0]          io_in;
    logic [32*N_OUT_REGS-1:0] io_out;

    data_memory_ctrl #(
        .RAM_WORDS  (RAM_WORDS),
        .N_OUT_REGS (N_OUT_REGS),
        .IN_W       (IN_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .req           (req),
        .wren          (wren),
        .address       (address),
        .mem_mode      (mem_mode),
        .mem_unsigned  (mem_unsigned),
        .data          (data),
        .stall         (stall),
        .q             (q),
        .q_valid       (q_valid),
        .misalign_err  (misalign_err),
        .io_input_bus  (io_in),
        .io_output_bus (io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] om [N_OUT_REGS];   // output register model

    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every q_valid pulse must match the oldest load
    always @(negedge clk) begin : mon
        exp_t e;
        if (q_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_value("q_valid_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_value(e.tag, q, e.val);
            end
        end
    end

    // Starts and ends at posedge+1; holds the request while stall is high
    task automatic access(input logic wr, input logic [31:0] a,
                          input logic [1:0] m, input logic u,
                          input logic [31:0] d, output int stalls);
        logic s;
        stalls = 0;
        req = 1'b1; wren = wr; address = a; mem_mode = m;
        mem_unsigned = u; data = d;
        for (int i = 0; i < 4; i++) begin
            #1;
            s = stall;
            if (s === 1'b1) stalls++;
            @(posedge clk); #1;
            if (s !== 1'b1) break;
        end
        req = 1'b0; wren = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] m,
                         input logic [31:0] d);
        int st;
        access(1'b1, a, m, 1'b0, d, st);
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [1:0] m, input logic u,
                        input logic [31:0] exp);
        int st;
        sb_q.push_back('{tag: tag, val: exp});
        access(1'b0, a, m, u, 32'h0, st);
    endtask

    function automatic logic [127:0] out_model();
        return {om[3], om[2], om[1], om[0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        for (int k = 0; k < N_OUT_REGS; k++) om[k] = '0;
        reset = 1'b1; req = 1'b0; wren = 1'b0; address = '0;
        mem_mode = MEM_WORD; mem_unsigned = 1'b0; data = '0; io_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_stall",    stall, 0);
        check_value("rst_q",        q, 0);
        check_value("rst_q_valid",  q_valid, 0);
        check_value("rst_misalign", misalign_err, 0);
        check_value("rst_out_bus",  io_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Output registers
        load("out1_init", 32'h2004, MEM_WORD, 1'b0, 32'h0);
        store(32'h2004, MEM_WORD, 32'h1234_5678);
        om[1] = 32'h1234_5678;
        check_value("out1_store", io_out, out_model());
        load("out1_rb", 32'h2004, MEM_WORD, 1'b0, 32'h1234_5678);
        store(32'h2001, MEM_BYTE, 32'h0000_005A);
        om[0] = 32'h0000_5A00;
        check_value("out0_byte", io_out, out_model());

        // Byte store then back-to-back loads (write-first)
        store(32'h0003, MEM_BYTE, 32'h0000_0080);
        load("ld_b_signed",   32'h0003, MEM_BYTE, 1'b0, 32'hFFFF_FF80);
        load("ld_b_unsigned", 32'h0003, MEM_BYTE, 1'b1, 32'h0000_0080);

        // Misaligned word store/load split across words 0 and 1
        access(1'b1, 32'h0001, MEM_WORD, 1'b0, 32'hAABB_CCDD, st);
        check_value("split_st_stall", st, 1);
        sb_q.push_back('{tag: "split_ld_word", val: 32'hAABB_CCDD});
        access(1'b0, 32'h0001, MEM_WORD, 1'b0, 32'h0, st);
        check_value("split_ld_stall", st, 1);
        load("lane1", 32'h0001, MEM_BYTE, 1'b1, 32'h0000_00DD);
        load("lane3", 32'h0003, MEM_BYTE, 1'b1, 32'h0000_00BB);
        load("lane4", 32'h0004, MEM_BYTE, 1'b1, 32'h0000_00AA);
        load("split_ld_half", 32'h0003, MEM_HALF, 1'b0, 32'hFFFF_AABB);
        load("half_off1_s",   32'h0001, MEM_HALF, 1'b0, 32'hFFFF_CCDD);
        load("half_off1_u",   32'h0001, MEM_HALF, 1'b1, 32'h0000_CCDD);

        // Half store at the last byte wraps to word 0
        store(4*RAM_WORDS - 1, MEM_HALF, 32'h0000_BEEF);
        load("wrap_half", 4*RAM_WORDS - 1, MEM_HALF, 1'b1, 32'h0000_BEEF);
        load("wrap_top",  4*RAM_WORDS - 1, MEM_BYTE, 1'b1, 32'h0000_00EF);
        load("wrap_w0b0", 32'h0000, MEM_BYTE, 1'b1, 32'h0000_00BE);
        load("mode3_word", 32'h0000, 2'b11, 1'b0, 32'hBBCC_DDBE);

        // Input port: synchronised value and sticky edge flags
        io_in[10] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        load("in_sync",    32'h1000, MEM_WORD, 1'b0, 32'h0000_0400);
        load("flag_first", 32'h1004, MEM_WORD, 1'b0, 32'h0000_0400);
        load("flag_clear", 32'h1004, MEM_WORD, 1'b0, 32'h0);
        io_in[3] = 1'b1;                 // edge reaches the flags in 3 edges
        @(posedge clk); #1;
        @(posedge clk); #1;
        load("flag_race_rd", 32'h1004, MEM_WORD, 1'b0, 32'h0);
        load("flag_race_kept", 32'h1004, MEM_WORD, 1'b0, 32'h0000_0008);
        store(32'h1000, MEM_WORD, 32'hFFFF_FFFF);
        load("in_ro", 32'h1000, MEM_WORD, 1'b0, 32'h0000_0408);

        // Out-of-range output register and unmapped region
        store(32'h2010, MEM_WORD, 32'hDEAD_BEEF);
        load("out_oor", 32'h2010, MEM_WORD, 1'b0, 32'h0);
        check_value("out_oor_bus", io_out, out_model());
        store(32'h3000, MEM_WORD, 32'h0000_0055);
        check_value("aligned_no_err", misalign_err, 0);
        load("unmapped", 32'h3000, MEM_WORD, 1'b0, 32'h0);

        // Misaligned IO accesses are rejected, not split
        access(1'b1, 32'h2002, MEM_WORD, 1'b0, 32'hFFFF_FFFF, st);
        check_value("io_mis_err", misalign_err, 1);
        check_value("io_mis_nostall", st, 0);
        check_value("io_mis_bus", io_out, out_model());
        load("io_mis_load", 32'h2000, MEM_HALF, 1'b0, 32'h0000_5A00);
        load("io_mis_ld0", 32'h2003, MEM_HALF, 1'b0, 32'h0);
        check_value("io_mis_ld_err", misalign_err, 1);

        // Reset during SPLIT aborts the second write
        store(32'h0100, MEM_WORD, 32'h0);
        store(32'h0104, MEM_WORD, 32'hCAFE_F00D);
        req = 1'b1; wren = 1'b1; address = 32'h0101; mem_mode = MEM_WORD;
        mem_unsigned = 1'b0; data = 32'h1122_3344;
        #1;
        check_value("rst_split_stall", stall, 1);
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0; wren = 1'b0;
        @(posedge clk); #1;
        check_value("rst_split_stall_after", stall, 0);
        check_value("rst_split_qv", q_valid, 0);
        check_value("rst_split_q", q, 0);
        for (int k = 0; k < N_OUT_REGS; k++) om[k] = '0;
        check_value("rst_split_bus", io_out, out_model());
        reset = 1'b0;
        load("rst_split_hi", 32'h0104, MEM_WORD, 1'b0, 32'hCAFE_F00D);
        load("rst_split_lo", 32'h0100, MEM_WORD, 1'b0, 32'h2233_4400);

        repeat (3) @(posedge clk);
        #1;
        check_value("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
